decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  ID stage and ID/EX pipeline register of the 5-stage RV32I core. Drives the register-file
//  read addresses from the fetched instruction and bypasses a same-cycle writeback, since the
//  register file writes synchronously. Decodes fields and immediates, detects load-use
//  hazards, and registers the result into EX with stall/flush/bubble control.
// PARAMETERS
//  XLEN        32  datapath width
//  RESET_PC    0   value of ex_pc on reset
// PORTS
//  clk          in   1     clock, rising edge
//  reset        in   1     asynchronous, active-high
//  if_valid     in   1     IF/ID holds a valid instruction
//  if_pc        in   XLEN  PC of instruction in ID
//  if_inst      in   32    instruction in ID
//  rs1_addr     out  5     to register file, = if_inst[19:15] (combinational)
//  rs2_addr     out  5     to register file, = if_inst[24:20] (combinational)
//  rs1_data     in   XLEN  register file read data (x0 already zeroed)
//  rs2_data     in   XLEN  register file read data
//  wb_en        in   1     writeback write enable (same net as register file write_en)
//  wb_addr      in   5     writeback destination
//  wb_value     in   XLEN  writeback data
//  ex_stall     in   1     EX cannot accept; hold ID/EX
//  flush        in   1     taken branch/jump resolved in EX; kill the instruction in ID
//  id_stall     out  1     to IF: hold IF/ID this cycle (combinational)
//  ex_valid     out  1     ID/EX slot valid
//  ex_pc        out  XLEN
//  ex_rs1_val   out  XLEN  bypassed operand 1
//  ex_rs2_val   out  XLEN  bypassed operand 2
//  ex_imm       out  XLEN  sign-extended immediate
//  ex_rd        out  5
//  ex_rd_we     out  1     0 when rd==0 or opcode has no rd (S, B)
//  ex_opcode    out  7
//  ex_funct3    out  3
//  ex_funct7b5  out  1     inst[30]
//  ex_is_load   out  1
//  ex_illegal   out  1     opcode not in RV32I base set
// BEHAVIOUR
//  - Reset (async): ex_valid, ex_rd_we, ex_is_load and ex_illegal are 0; all ex_* data are 0;
//    ex_pc = RESET_PC.
//  - Bypass: rsN_val = (wb_en && wb_addr!=0 && wb_addr==rsN_addr) ? wb_value : rsN_data.
//  - use_rs1 is true for all opcodes except LUI, AUIPC and JAL. use_rs2 is true for OP, STORE
//    and BRANCH only.
//  - load_use = if_valid && ex_valid && ex_is_load && ex_rd!=0 &&
//    ((use_rs1 && ex_rd==rs1_addr) || (use_rs2 && ex_rd==rs2_addr)).
//  - id_stall = ex_stall || (load_use && !flush).
//  - ID/EX update priority at posedge, one-cycle latency:
//    1. ex_stall:  every ex_* holds. Flush is ignored; its source holds flush until
//       ex_stall drops.
//    2. flush:     ex_valid<=0; other fields are don't-care.
//    3. load_use:  ex_valid<=0 (bubble); IF/ID is held through id_stall. Next cycle the load
//       has left EX and the instruction issues normally.
//    4. otherwise: ex_valid<=if_valid; all fields are loaded from decode.
//  - Immediates: I/S/B/U/J formats per RV32I; B and J have bit0=0; all sign-extended from
//    inst[31]. Opcodes without an immediate give imm=0.
//  - Illegal opcode: issues with ex_valid=1, ex_illegal=1, ex_rd_we=0.
//  - A WB write to the same register in the same cycle as a load-use bubble needs no special
//    case: the register file holds the value by the reissue cycle.
// STRUCTURE
//  - define.vh: opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC,
//    SYSTEM, MISC_MEM) and the XLEN default.
//  - Sub-module imm_gen: combinational, inst[31:0] -> imm[XLEN-1:0] plus format decode.
//  - The remaining logic is one always block for ID/EX with async reset, plus combinational
//    hazard and bypass logic.
// TESTING
//  1. Assert reset mid-stream with ex_valid=1 -> all outputs take reset values immediately,
//     without waiting for clk.
//  2. addi x5,x0,-1 (0xFFF00293) -> next cycle ex_imm=0xFFFFFFFF, ex_rd=5, ex_rd_we=1;
//     beq imm=-4 -> ex_imm=0xFFFFFFFC.
//  3. Bypass: ID add x3,x1,x2 with wb_en=1, wb_addr=1, wb_value=0x1234 and rs1_data stale
//     -> ex_rs1_val=0x1234. Same case with wb_addr=0 -> no bypass.
//  4. Load-use: lw x6 in EX, add x7,x6,x1 in ID -> id_stall=1 for exactly 1 cycle, one
//     bubble, then add issues. lui x6 in ID instead -> no stall.
//  5. Flush with if_valid=1 -> ex_valid=0 next cycle. Flush with ex_stall=1 -> ID/EX
//     unchanged.
//  6. ex_stall held 3 cycles -> ex_* stable, id_stall=1 throughout; a store to x0 gives
//     ex_rd_we=0.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - RV32I opcode constants, immediate formats and ID/EX control bundle
package decode_stage_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

  typedef struct packed {
    logic [4:0] rd;
    logic       rd_we;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       is_load;
    logic       illegal;
  } ex_ctrl_t;

  // OP has no immediate; unknown opcodes also fall through to FMT_NONE
  function automatic imm_fmt_e fmt_of(input logic [6:0] opc);
    case (opc)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR,
      OPC_SYSTEM, OPC_MISC_MEM:   fmt_of = FMT_I;
      OPC_STORE:                  fmt_of = FMT_S;
      OPC_BRANCH:                 fmt_of = FMT_B;
      OPC_LUI, OPC_AUIPC:         fmt_of = FMT_U;
      OPC_JAL:                    fmt_of = FMT_J;
      default:                    fmt_of = FMT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// rtl/decode_stage_imm_gen.sv - immediate generation and per-opcode format decode
module decode_stage_imm_gen
  import decode_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output logic            legal,
  output logic            use_rs1,
  output logic            use_rs2,
  output logic            has_rd
);

  logic [6:0]  opc;
  imm_fmt_e    fmt;
  logic [31:0] imm32;

  assign opc = inst[6:0];
  assign fmt = fmt_of(opc);

  always_comb begin
    imm32 = 32'd0;
    case (fmt)
      FMT_I: imm32 = {{20{inst[31]}}, inst[31:20]};
      FMT_S: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B: imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U: imm32 = {inst[31:12], 12'd0};
      FMT_J: imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
  end

  assign imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

  always_comb begin
    legal = 1'b0;
    case (opc)
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL,
      OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_SYSTEM, OPC_MISC_MEM: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  assign use_rs1 = !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
  assign use_rs2 = (opc == OPC_OP || opc == OPC_STORE || opc == OPC_BRANCH);
  assign has_rd  = !(opc == OPC_STORE || opc == OPC_BRANCH);

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I ID stage: operand bypass, load-use hazard and ID/EX register
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_inst,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_value,
  input  logic            ex_stall,
  input  logic            flush,
  output logic            id_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic            ex_rd_we,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic            ex_is_load,
  output logic            ex_illegal
);

  logic [XLEN-1:0] imm;
  logic            legal;
  logic            use_rs1;
  logic            use_rs2;
  logic            has_rd;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            load_use;
  ex_ctrl_t        ctrl_dec;

  logic            valid_d,   valid_q;
  logic [XLEN-1:0] pc_d,      pc_q;
  logic [XLEN-1:0] rs1_val_d, rs1_val_q;
  logic [XLEN-1:0] rs2_val_d, rs2_val_q;
  logic [XLEN-1:0] imm_d,     imm_q;
  ex_ctrl_t        ctrl_d,    ctrl_q;

  decode_stage_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst    (if_inst),
    .imm     (imm),
    .legal   (legal),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2),
    .has_rd  (has_rd)
  );

  assign rs1_addr = if_inst[19:15];
  assign rs2_addr = if_inst[24:20];

  // Register file writes at the edge, so a same-cycle writeback must be forwarded here
  assign rs1_val = (wb_en && wb_addr != 5'd0 && wb_addr == rs1_addr) ? wb_value : rs1_data;
  assign rs2_val = (wb_en && wb_addr != 5'd0 && wb_addr == rs2_addr) ? wb_value : rs2_data;

  assign load_use = if_valid && valid_q && ctrl_q.is_load && ctrl_q.rd != 5'd0 &&
                    ((use_rs1 && ctrl_q.rd == rs1_addr) || (use_rs2 && ctrl_q.rd == rs2_addr));

  assign id_stall = ex_stall || (load_use && !flush);

  always_comb begin
    ctrl_dec          = '0;
    ctrl_dec.rd       = if_inst[11:7];
    ctrl_dec.rd_we    = has_rd && legal && (if_inst[11:7] != 5'd0);
    ctrl_dec.opcode   = if_inst[6:0];
    ctrl_dec.funct3   = if_inst[14:12];
    ctrl_dec.funct7b5 = if_inst[30];
    ctrl_dec.is_load  = (if_inst[6:0] == OPC_LOAD);
    ctrl_dec.illegal  = !legal;
  end

  // Flush and bubble only clear valid; the payload is don't-care and simply holds
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    rs1_val_d = rs1_val_q;
    rs2_val_d = rs2_val_q;
    imm_d     = imm_q;
    ctrl_d    = ctrl_q;
    if (!ex_stall) begin
      if (flush || load_use) begin
        valid_d = 1'b0;
      end else begin
        valid_d   = if_valid;
        pc_d      = if_pc;
        rs1_val_d = rs1_val;
        rs2_val_d = rs2_val;
        imm_d     = imm;
        ctrl_d    = ctrl_dec;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      pc_q      <= RESET_PC;
      rs1_val_q <= '0;
      rs2_val_q <= '0;
      imm_q     <= '0;
      ctrl_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      rs1_val_q <= rs1_val_d;
      rs2_val_q <= rs2_val_d;
      imm_q     <= imm_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_pc       = pc_q;
  assign ex_rs1_val  = rs1_val_q;
  assign ex_rs2_val  = rs2_val_q;
  assign ex_imm      = imm_q;
  assign ex_rd       = ctrl_q.rd;
  assign ex_rd_we    = ctrl_q.rd_we;
  assign ex_opcode   = ctrl_q.opcode;
  assign ex_funct3   = ctrl_q.funct3;
  assign ex_funct7b5 = ctrl_q.funct7b5;
  assign ex_is_load  = ctrl_q.is_load;
  assign ex_illegal  = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed bench for decode_stage
module tb_decode_stage;

  localparam int          XLEN  = 32;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  localparam logic [31:0] I_ADDI_M1   = 32'hFFF0_0293; // addi x5,x0,-1
  localparam logic [31:0] I_BEQ_M4    = 32'hFE20_8EE3; // beq x1,x2,-4
  localparam logic [31:0] I_ADD_312   = 32'h0020_81B3; // add x3,x1,x2
  localparam logic [31:0] I_ADD_302   = 32'h0020_01B3; // add x3,x0,x2
  localparam logic [31:0] I_LW_6      = 32'h0000_A303; // lw x6,0(x1)
  localparam logic [31:0] I_ADD_761   = 32'h0013_03B3; // add x7,x6,x1
  localparam logic [31:0] I_LUI_6     = 32'h0003_0337; // lui x6,0x30 (rs1 field = 6)
  localparam logic [31:0] I_SW        = 32'h0020_A623; // sw x2,12(x1)
  localparam logic [31:0] I_ILLEGAL   = 32'h0000_037F;

  logic            clk = 1'b0;
  logic            reset;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_inst;
  logic [4:0]      rs1_addr, rs2_addr;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            wb_en;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_value;
  logic            ex_stall, flush, id_stall;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]      ex_rd;
  logic            ex_rd_we;
  logic [6:0]      ex_opcode;
  logic [2:0]      ex_funct3;
  logic            ex_funct7b5, ex_is_load, ex_illegal;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(XLEN), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_value(wb_value), .ex_stall(ex_stall),
    .flush(flush), .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm), .ex_rd(ex_rd),
    .ex_rd_we(ex_rd_we), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
    .ex_funct7b5(ex_funct7b5), .ex_is_load(ex_is_load), .ex_illegal(ex_illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc);
    if_valid = 1'b1;
    if_inst  = inst;
    if_pc    = pc;
    #1;
  endtask

  initial begin
    reset = 1'b1; if_valid = 1'b0; if_pc = '0; if_inst = '0;
    rs1_data = '0; rs2_data = '0; wb_en = 1'b0; wb_addr = '0; wb_value = '0;
    ex_stall = 1'b0; flush = 1'b0;
    tick(); tick();
    check("rst_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_pc", ex_pc, RST_PC);
    check("rst_imm", ex_imm, 32'd0);
    check("rst_rd_we", {31'd0, ex_rd_we}, 32'd0);
    reset = 1'b0;

    // addi x5,x0,-1
    drive(I_ADDI_M1, 32'h10);
    check("addi_rs1_addr", {27'd0, rs1_addr}, 32'd0);
    check("addi_rs2_addr", {27'd0, rs2_addr}, 32'd31);
    tick();
    check("addi_valid", {31'd0, ex_valid}, 32'd1);
    check("addi_imm", ex_imm, 32'hFFFF_FFFF);
    check("addi_rd", {27'd0, ex_rd}, 32'd5);
    check("addi_rd_we", {31'd0, ex_rd_we}, 32'd1);
    check("addi_pc", ex_pc, 32'h10);
    check("addi_opcode", {25'd0, ex_opcode}, 32'h13);

    // beq x1,x2,-4
    drive(I_BEQ_M4, 32'h14);
    tick();
    check("beq_imm", ex_imm, 32'hFFFF_FFFC);
    check("beq_rd_we", {31'd0, ex_rd_we}, 32'd0);
    check("beq_funct3", {29'd0, ex_funct3}, 32'd0);

    // bypass rs1 from writeback, stale register file data
    drive(I_ADD_312, 32'h18);
    rs1_data = 32'hDEAD; rs2_data = 32'h55;
    wb_en = 1'b1; wb_addr = 5'd1; wb_value = 32'h1234;
    tick();
    check("byp_rs1", ex_rs1_val, 32'h1234);
    check("byp_rs2_nobyp", ex_rs2_val, 32'h55);
    // bypass rs2
    wb_addr = 5'd2; wb_value = 32'hBEEF;
    tick();
    check("byp_rs2", ex_rs2_val, 32'hBEEF);
    check("byp_rs1_nobyp", ex_rs1_val, 32'hDEAD);
    // writeback to x0 is never forwarded
    drive(I_ADD_302, 32'h1C);
    rs1_data = 32'd0; wb_addr = 5'd0; wb_value = 32'h1234;
    tick();
    check("byp_x0", ex_rs1_val, 32'd0);
    wb_en = 1'b0;

    // load-use: lw x6 then add x7,x6,x1
    drive(I_LW_6, 32'h20);
    tick();
    check("lw_is_load", {31'd0, ex_is_load}, 32'd1);
    drive(I_ADD_761, 32'h24);
    check("lu_stall_1", {31'd0, id_stall}, 32'd1);
    tick();
    check("lu_bubble", {31'd0, ex_valid}, 32'd0);
    check("lu_stall_2", {31'd0, id_stall}, 32'd0);
    tick();
    check("lu_issue_valid", {31'd0, ex_valid}, 32'd1);
    check("lu_issue_rd", {27'd0, ex_rd}, 32'd7);
    check("lu_issue_pc", ex_pc, 32'h24);

    // lui with rs1 field equal to the load's rd does not stall
    drive(I_LW_6, 32'h28);
    tick();
    drive(I_LUI_6, 32'h2C);
    check("lui_no_stall", {31'd0, id_stall}, 32'd0);
    tick();
    check("lui_valid", {31'd0, ex_valid}, 32'd1);
    check("lui_imm", ex_imm, 32'h0003_0000);

    // flush kills the instruction in ID
    drive(I_ADDI_M1, 32'h30);
    flush = 1'b1;
    tick();
    check("flush_valid", {31'd0, ex_valid}, 32'd0);
    flush = 1'b0;

    // flush during ex_stall is ignored; ID/EX holds for 3 stalled cycles
    drive(I_ADDI_M1, 32'h40);
    tick();
    check("pre_stall_valid", {31'd0, ex_valid}, 32'd1);
    ex_stall = 1'b1; flush = 1'b1;
    drive(I_BEQ_M4, 32'h44);
    check("stall_id_stall_0", {31'd0, id_stall}, 32'd1);
    tick();
    check("stall_flush_valid", {31'd0, ex_valid}, 32'd1);
    check("stall_flush_pc", ex_pc, 32'h40);
    flush = 1'b0;
    drive(I_SW, 32'h48);
    check("stall_id_stall_1", {31'd0, id_stall}, 32'd1);
    tick();
    check("stall_pc_1", ex_pc, 32'h40);
    drive(I_LUI_6, 32'h4C);
    check("stall_id_stall_2", {31'd0, id_stall}, 32'd1);
    tick();
    check("stall_pc_2", ex_pc, 32'h40);
    check("stall_imm_2", ex_imm, 32'hFFFF_FFFF);
    check("stall_rd_2", {27'd0, ex_rd}, 32'd5);
    ex_stall = 1'b0;

    // store: no rd write
    drive(I_SW, 32'h50);
    tick();
    check("sw_valid", {31'd0, ex_valid}, 32'd1);
    check("sw_imm", ex_imm, 32'd12);
    check("sw_rd_we", {31'd0, ex_rd_we}, 32'd0);

    // illegal opcode issues flagged
    drive(I_ILLEGAL, 32'h54);
    tick();
    check("ill_valid", {31'd0, ex_valid}, 32'd1);
    check("ill_flag", {31'd0, ex_illegal}, 32'd1);
    check("ill_rd_we", {31'd0, ex_rd_we}, 32'd0);
    check("ill_imm", ex_imm, 32'd0);

    // asynchronous reset between edges
    drive(I_ADDI_M1, 32'h58);
    tick();
    check("pre_arst_valid", {31'd0, ex_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", {31'd0, ex_valid}, 32'd0);
    check("arst_pc", ex_pc, RST_PC);
    check("arst_imm", ex_imm, 32'd0);
    check("arst_rd_we", {31'd0, ex_rd_we}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
